// File: rtl/mul3_pkg.sv
// rtl/mul3_pkg.sv - shared types and widths for the serial 3*z+r reconstructor
package mul3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int REM_W   = 2;
  localparam int CARRY_W = 2;

  // Remainder 3 is out of range for a divide-by-3 and is flagged, not rejected
  function automatic logic rem_illegal(input logic [REM_W-1:0] r);
    return (r == 2'd3);
  endfunction

endpackage

// File: rtl/mul3_bit_cell.sv
// rtl/mul3_bit_cell.sv - one bit slice of z + 2*z + carry, carry kept in 0..2
module mul3_bit_cell
  import mul3_pkg::*;
(
  input  logic               zi,
  input  logic               prev,
  input  logic [CARRY_W-1:0] carry,
  output logic               xbit,
  output logic [CARRY_W-1:0] carry_next
);

  // prev is z shifted up one place, i.e. the 2*z term at this bit position
  logic [2:0] s;

  assign s          = {2'b00, zi} + {2'b00, prev} + {1'b0, carry};
  assign xbit       = s[0];
  assign carry_next = s[2:1];

endmodule

// File: rtl/mul3_recon_serial.sv
// rtl/mul3_recon_serial.sv - bit-serial x = 3*z + r, LSB first, with parallel result
module mul3_recon_serial
  import mul3_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] z,
  input  logic [REM_W-1:0] r,
  output logic             bit_valid,
  output logic             x_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] x,
  output logic             err
);

  localparam int XW    = WIDTH + 2;
  localparam int CNT_W = $clog2(XW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XW - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   zsh;
  logic [CARRY_W-1:0] carry, carry_next;
  logic               prev;
  logic [CNT_W-1:0]   cnt;
  logic               sbit;

  // zsh shifts right with zero fill, so bits beyond WIDTH read as 0
  mul3_bit_cell u_cell (
    .zi         (zsh[0]),
    .prev       (prev),
    .carry      (carry),
    .xbit       (sbit),
    .carry_next (carry_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    bit_valid  = 1'b0;
    x_bit      = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bit_valid = 1'b1;
        x_bit     = sbit;
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result bits enter at the top and reach position i after all XW shifts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zsh   <= '0;
      carry <= '0;
      prev  <= 1'b0;
      cnt   <= '0;
      x     <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            zsh   <= z;
            carry <= CARRY_W'(r);
            prev  <= 1'b0;
            cnt   <= '0;
            x     <= '0;
            err   <= rem_illegal(r);
          end
        end
        SHIFT: begin
          zsh   <= {1'b0, zsh[WIDTH-1:1]};
          carry <= carry_next;
          prev  <= zsh[0];
          x     <= {sbit, x[XW-1:1]};
          cnt   <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul3_recon_serial.sv
// tb/tb_mul3_recon_serial.sv - directed and random checks of mul3_recon_serial against 3*z+r
module tb_mul3_recon_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_bit_valid, a_x_bit, a_out_valid, a_out_ready, a_err;
  logic [3:0] a_z;
  logic [1:0] a_r;
  logic [5:0] a_x;

  logic        b_in_valid, b_in_ready, b_bit_valid, b_x_bit, b_out_valid, b_out_ready, b_err;
  logic [9:0]  b_z;
  logic [1:0]  b_r;
  logic [11:0] b_x;

  int total = 0;
  int bad   = 0;

  mul3_recon_serial #(.WIDTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .z(a_z), .r(a_r),
    .bit_valid(a_bit_valid), .x_bit(a_x_bit),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .x(a_x), .err(a_err)
  );

  mul3_recon_serial #(.WIDTH(10)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .z(b_z), .r(b_r),
    .bit_valid(b_bit_valid), .x_bit(b_x_bit),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .x(b_x), .err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One WIDTH=4 operation; hold = cycles out_ready stays low in DONE, early = out_ready high while shifting
  task automatic a_op(input logic [3:0] z, input logic [1:0] r, input int hold, input bit early);
    int         full;
    logic [5:0] expx;
    full = 3 * int'(z) + int'(r);
    expx = full[5:0];
    @(negedge clk);
    chk("a_in_ready_idle", a_in_ready, 1);
    a_z = z; a_r = r; a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_z = 4'($urandom); a_r = 2'($urandom);
    if (early) a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("a_bit_valid", a_bit_valid, 1);
      chk("a_x_bit", a_x_bit, expx[i]);
      chk("a_in_ready_busy", a_in_ready, 0);
      chk("a_out_valid_early", a_out_valid, 0);
    end
    @(negedge clk);
    chk("a_out_valid", a_out_valid, 1);
    chk("a_x", a_x, expx);
    chk("a_err", a_err, (r == 2'd3));
    chk("a_bit_valid_done", a_bit_valid, 0);
    chk("a_x_bit_done", a_x_bit, 0);
    for (int i = 0; i < hold; i++) begin
      a_in_valid = 1'b1;
      a_z = 4'($urandom); a_r = 2'($urandom);
      @(negedge clk);
      chk("a_hold_out_valid", a_out_valid, 1);
      chk("a_hold_x", a_x, expx);
      chk("a_hold_err", a_err, (r == 2'd3));
      chk("a_hold_in_ready", a_in_ready, 0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("a_release_out_valid", a_out_valid, 0);
    chk("a_release_in_ready", a_in_ready, 1);
  endtask

  // One WIDTH=10 operation with out_ready high from the accept onward
  task automatic b_op(input logic [9:0] z, input logic [1:0] r, output logic [11:0] got);
    int          full;
    logic [11:0] expx, stream;
    int          pulses;
    full = 3 * int'(z) + int'(r);
    expx = full[11:0];
    stream = '0;
    pulses = 0;
    @(negedge clk);
    b_z = z; b_r = r; b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_bit_valid) pulses++;
      stream[i] = b_x_bit;
    end
    chk("b_bit_pulses", pulses, 12);
    chk("b_stream", stream, expx);
    @(negedge clk);
    chk("b_out_valid", b_out_valid, 1);
    chk("b_x", b_x, expx);
    chk("b_err", b_err, (r == 2'd3));
    got = b_x;
    @(posedge clk);
    #1;
    b_out_ready = 1'b0;
    @(negedge clk);
    chk("b_in_ready_after", b_in_ready, 1);
  endtask

  initial begin
    logic [11:0] got;
    int          v;
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_z = '0; a_r = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_z = '0; b_r = '0;
    #12;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_bit_valid", a_bit_valid, 0);
    chk("rst_x_bit", a_x_bit, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_x", a_x, 0);
    chk("rst_err", a_err, 0);
    @(negedge clk);
    rst = 1'b0;

    a_op(4'b1010, 2'd1, 0, 1'b0);
    a_op(4'b1111, 2'd2, 0, 1'b1);
    a_op(4'b0000, 2'd0, 0, 1'b0);
    a_op(4'b1111, 2'd3, 0, 1'b0);
    a_op(4'b0011, 2'd0, 0, 1'b0);
    a_op(4'b1001, 2'd1, 20, 1'b0);

    // Abort an r==3 operation mid-shift with an asynchronous reset
    @(negedge clk);
    a_z = 4'b0110; a_r = 2'd3; a_in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_bit_valid_pre", a_bit_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", a_in_ready, 1);
    chk("abort_bit_valid", a_bit_valid, 0);
    chk("abort_x_bit", a_x_bit, 0);
    chk("abort_out_valid", a_out_valid, 0);
    chk("abort_x", a_x, 0);
    chk("abort_err", a_err, 0);
    @(negedge clk);
    rst = 1'b0;
    a_op(4'd5, 2'd0, 0, 1'b0);

    v = 848;
    b_op(10'(v / 3), 2'(v % 3), got);
    chk("b_roundtrip_848", got, 12'd848);

    for (int k = 0; k < 25; k++) begin
      b_op(10'($urandom), 2'($urandom_range(0, 3)), got);
    end
    for (int k = 0; k < 8; k++) begin
      a_op(4'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
